// File: rtl/viterbi_pkg.sv
// Shared constants, types and code-trellis helpers for the K=3, rate-1/2 Viterbi decoder.
package viterbi_pkg;

    localparam int K          = 3;
    localparam int NUM_STATES = 4;
    localparam int BM_W       = 2;

    localparam logic [K-1:0] G1 = 3'b111;
    localparam logic [K-1:0] G2 = 3'b101;

    // {s1,s2}: s1 is the most recent input bit
    typedef logic [1:0] state_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } dec_state_t;

    function automatic logic [1:0] expected_sym(input state_t state, input logic m);
        logic [K-1:0] taps;
        taps = {m, state};
        return {^(taps & G1), ^(taps & G2)};
    endfunction

    function automatic logic [BM_W-1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] diff;
        diff = a ^ b;
        return {1'b0, diff[1]} + {1'b0, diff[0]};
    endfunction

endpackage

// File: rtl/viterbi_acs.sv
// Add-compare-select for one trellis state: saturating adds, ties resolve to predecessor 0.
module viterbi_acs
    import viterbi_pkg::*;
#(
    parameter int PM_W = 6
) (
    input  logic [PM_W-1:0] pm0_i,
    input  logic [PM_W-1:0] pm1_i,
    input  logic [BM_W-1:0] bm0_i,
    input  logic [BM_W-1:0] bm1_i,
    output logic [PM_W-1:0] pm_o,
    output logic            dec_o
);

    localparam logic [PM_W-1:0] PM_MAX = '1;

    logic [PM_W:0]   sum0;
    logic [PM_W:0]   sum1;
    logic [PM_W-1:0] cand0;
    logic [PM_W-1:0] cand1;

    assign sum0  = {1'b0, pm0_i} + {{(PM_W + 1 - BM_W){1'b0}}, bm0_i};
    assign sum1  = {1'b0, pm1_i} + {{(PM_W + 1 - BM_W){1'b0}}, bm1_i};
    assign cand0 = sum0[PM_W] ? PM_MAX : sum0[PM_W-1:0];
    assign cand1 = sum1[PM_W] ? PM_MAX : sum1[PM_W-1:0];

    assign dec_o = (cand1 < cand0);
    assign pm_o  = dec_o ? cand1 : cand0;

endmodule

// File: rtl/viterbi_decoder.sv
// Hard-decision register-exchange Viterbi decoder; outputs each bit TB_DEPTH-1 symbols late
// and drains the remaining buffered bits from state 0 after a terminate request.
module viterbi_decoder
    import viterbi_pkg::*;
#(
    parameter int TB_DEPTH = 15,
    parameter int PM_W     = 6
) (
    input  logic clk,
    input  logic n_reset,
    input  logic shift,
    input  logic n1,
    input  logic n2,
    input  logic terminate,
    output logic msg_out,
    output logic out_valid,
    output logic busy
);

    localparam int CNT_W = $clog2(TB_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TB_DEPTH);
    localparam logic [CNT_W-1:0] CNT_OUT  = CNT_W'(TB_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PM_W-1:0]  PM_INIT  = PM_W'(1 << (PM_W - 2));

    dec_state_t          state_q, state_d;
    logic [PM_W-1:0]     pm_q   [NUM_STATES];
    logic [PM_W-1:0]     pm_d   [NUM_STATES];
    logic [TB_DEPTH-1:0] surv_q [NUM_STATES];
    logic [TB_DEPTH-1:0] surv_d [NUM_STATES];
    logic [CNT_W-1:0]    count_q, count_d;
    logic [CNT_W-1:0]    pending_q, pending_d;
    logic                msg_q, msg_d;
    logic                valid_q, valid_d;

    logic                accept;
    logic [1:0]          rx_sym;
    logic [PM_W-1:0]     pm_acs   [NUM_STATES];
    logic [PM_W-1:0]     pm_new   [NUM_STATES];
    logic                dec      [NUM_STATES];
    logic [TB_DEPTH-1:0] surv_new [NUM_STATES];
    logic                all_msb;
    state_t              best;
    logic [PM_W-1:0]     best_pm;
    logic                drain_bit;

    assign accept    = shift && (state_q != DRAIN);
    assign rx_sym    = {n1, n2};
    assign busy      = (state_q == DRAIN);
    assign msg_out   = msg_q;
    assign out_valid = valid_q;

    assign all_msb = pm_acs[0][PM_W-1] & pm_acs[1][PM_W-1] &
                     pm_acs[2][PM_W-1] & pm_acs[3][PM_W-1];

    // Next state {m,a} is reached from {a,0} or {a,1} with input bit m
    for (genvar gi = 0; gi < NUM_STATES; gi++) begin : g_acs
        localparam state_t NS = state_t'(gi);
        localparam state_t P0 = {NS[0], 1'b0};
        localparam state_t P1 = {NS[0], 1'b1};

        logic [BM_W-1:0] bm0;
        logic [BM_W-1:0] bm1;

        assign bm0 = hamming2(rx_sym, expected_sym(P0, NS[1]));
        assign bm1 = hamming2(rx_sym, expected_sym(P1, NS[1]));

        viterbi_acs #(
            .PM_W (PM_W)
        ) u_acs (
            .pm0_i (pm_q[P0]),
            .pm1_i (pm_q[P1]),
            .bm0_i (bm0),
            .bm1_i (bm1),
            .pm_o  (pm_acs[gi]),
            .dec_o (dec[gi])
        );

        assign surv_new[gi] = {dec[gi] ? surv_q[P1][TB_DEPTH-2:0] : surv_q[P0][TB_DEPTH-2:0], NS[1]};
        assign pm_new[gi]   = all_msb ? {1'b0, pm_acs[gi][PM_W-2:0]} : pm_acs[gi];
    end

    always_comb begin
        best    = state_t'(0);
        best_pm = pm_new[0];
        for (int i = 1; i < NUM_STATES; i++) begin
            if (pm_new[i] < best_pm) begin
                best    = state_t'(i);
                best_pm = pm_new[i];
            end
        end
    end

    // Zero-terminated stream: the surviving path into state 0 is the correct one
    always_comb begin
        drain_bit = 1'b0;
        for (int i = 0; i < TB_DEPTH; i++) begin
            if (pending_q == CNT_W'(i + 1)) begin
                drain_bit = surv_q[0][i];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        pm_d      = pm_q;
        surv_d    = surv_q;
        count_d   = count_q;
        pending_d = pending_q;
        msg_d     = msg_q;
        valid_d   = 1'b0;

        unique case (state_q)
            IDLE, RUN: begin
                if (accept) begin
                    pm_d    = pm_new;
                    surv_d  = surv_new;
                    count_d = (count_q == CNT_FULL) ? count_q : count_q + CNT_ONE;
                    if (count_q >= CNT_OUT) begin
                        msg_d   = surv_new[best][TB_DEPTH-1];
                        valid_d = 1'b1;
                    end
                    state_d = RUN;
                end
                if ((state_q == RUN) && terminate) begin
                    state_d   = DRAIN;
                    pending_d = (count_d > CNT_OUT) ? CNT_OUT : count_d;
                end
            end
            DRAIN: begin
                msg_d     = drain_bit;
                valid_d   = 1'b1;
                pending_d = pending_q - CNT_ONE;
                if (pending_q <= CNT_ONE) begin
                    state_d   = IDLE;
                    count_d   = '0;
                    pending_d = '0;
                    for (int i = 0; i < NUM_STATES; i++) begin
                        pm_d[i]   = (i == 0) ? '0 : PM_INIT;
                        surv_d[i] = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            pending_q <= '0;
            msg_q     <= 1'b0;
            valid_q   <= 1'b0;
            for (int i = 0; i < NUM_STATES; i++) begin
                pm_q[i]   <= (i == 0) ? '0 : PM_INIT;
                surv_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            pm_q      <= pm_d;
            surv_q    <= surv_d;
            count_q   <= count_d;
            pending_q <= pending_d;
            msg_q     <= msg_d;
            valid_q   <= valid_d;
        end
    end

endmodule

// File: doc/viterbi_decoder.md
Name: viterbi_decoder

Overview:
- Hard-decision Viterbi decoder for the team's rate-1/2, K=3 convolutional code.
  - Generators: g1=111 (7 octal) drives n1; g2=101 (5 octal) drives n2.
  - Encoder starts in the all-zero state and is terminated with zero tail bits.
- Accepts one (n1,n2) symbol pair per shift strobe and returns the decoded message bit stream, delayed by TB_DEPTH-1 symbols.
- Uses a register-exchange survivor memory. A terminate request drains the remaining buffered bits.
- Sits at the receive end of the channel, directly opposite the convolutional encoder.

Parameters:
- TB_DEPTH, 15: survivor register length in bits (minimum 4). Also sets decode latency in symbols.
- PM_W, 6: path-metric width in bits (minimum 4).

Ports:
- clk  input  1  system clock, rising edge
- n_reset  input  1  asynchronous active-low reset
- shift  input  1  symbol strobe; n1/n2 are valid this cycle
- n1  input  1  received g1 code bit
- n2  input  1  received g2 code bit
- terminate  input  1  one-cycle pulse: stream ended (tail zeros already sent); drain buffered bits
- msg_out  output  1  decoded message bit
- out_valid  output  1  msg_out is valid this cycle (one-cycle pulse per bit)
- busy  output  1  high while in DRAIN; shift and terminate are ignored while high

Behaviour:
- Clock and reset (already decided): one clock, clk. Reset n_reset is asynchronous, active-low.
- Reset values:
  - msg_out=0, out_valid=0, busy=0, fill count=0, pending=0, state IDLE.
  - PM[0]=0; PM[1..3]=2^(PM_W-2). All survivor registers cleared to 0.
- State encoding: index = {s1,s2}. s1 is the most recent input bit, s2 the one before it.
- Transition from {s1,s2} on input m:
  - Next state = {m,s1}.
  - Expected n1 = m^s1^s2; expected n2 = m^s2.
- Branch metric: Hamming distance between received {n1,n2} and expected {n1,n2}; range 0..2.
- ACS, performed on the clock edge of every cycle where shift=1 and busy=0:
  - Next state {m,a} has predecessors {a,0} and {a,1}.
  - Candidate metric = PM[pred] + BM.
  - Choose the smaller candidate; on a tie choose the predecessor {a,0}.
  - Metric adds saturate at 2^PM_W-1.
- Survivor update: surv_new[{m,a}] = {surv[pred][TB_DEPTH-2:0], m}. Bit 0 holds the newest bit.
- Normalisation: after ACS, if every new PM has its MSB set, clear the MSB of all four in the same update.
- Best state: lowest new PM; ties go to the lowest index.
- Output in FILL/RUN, on each accepted symbol:
  - fill count increments, saturating at TB_DEPTH.
  - If count before increment ≥ TB_DEPTH-1: register msg_out = surv_new[best][TB_DEPTH-1] and pulse out_valid=1 for one cycle.
  - Result: symbol k's decoded bit appears in the cycle after symbol k+TB_DEPTH-1 is accepted.
- States and transitions:
  - IDLE→RUN on the first accepted shift.
  - RUN→DRAIN on terminate. If shift and terminate are both high in the same cycle, the symbol is processed first and DRAIN starts next cycle.
  - Entering DRAIN: pending = min(count, TB_DEPTH-1).
  - DRAIN: busy=1. Each cycle, output surv[0][pending-1] with out_valid=1, then decrement pending. State 0 is used because the stream is zero-terminated.
  - When pending reaches 0: metrics and survivors return to reset values, count=0, →IDLE, busy=0 next cycle.
- Boundary cases:
  - terminate in IDLE: ignored.
  - terminate with count<TB_DEPTH-1: drains count bits; no RUN outputs were ever produced.
  - shift or terminate during DRAIN: ignored, with no effect on state.
  - Gaps between shift strobes: state holds; out_valid=0.
  - n_reset low mid-stream: immediate return to reset values; in-flight bits are discarded.

Decomposition:
- Package viterbi_pkg holds:
  - K=3, G1=3'b111, G2=3'b101.
  - Function expected_sym(state, m) returning the 2-bit expected code pair.
  - Typedef state_t (2-bit).
  - Enum dec_state_t {IDLE, RUN, DRAIN}.
- One natural sub-module: viterbi_acs (combinational). Inputs: two predecessor metrics and two branch metrics. Outputs: chosen metric and decision bit. Instantiated four times.

Test Plan:
- Clean stream, TB_DEPTH=4:
  - Stimulus: symbols 11,01,01,11,11,01,01,11,00 (message 1,1,0,0,1,1,0,0,0 from zero state), then terminate.
  - Required: RUN outputs 1,1,0,0,1,1 after symbols 4..9; DRAIN outputs 0,0,0 on three consecutive cycles; busy high exactly 3 cycles.
- Single-bit error, TB_DEPTH=15:
  - Stimulus: 40-bit pseudo-random message plus 2 zero tail bits; flip n1 of symbol 10.
  - Required: all 42 decoded bits match the message; first out_valid occurs the cycle after symbol 15.
- Gapped strobes: same stream as the first scenario with shift low 1-3 cycles between symbols -> identical output bit sequence; out_valid only follows accepted symbols.
- Simultaneous and ignored controls:
  - shift+terminate together on the final symbol -> symbol decoded, then drain.
  - shift pulses during DRAIN -> no change to the drained bits.
- Mid-stream reset: n_reset low for one cycle after symbol 5 -> outputs 0 immediately; a fresh clean stream afterwards decodes correctly.
- Metric normalisation: 200 all-"11" symbols with alternating errors, PM_W=4 -> no PM overflow; decoded output matches a reference model bit-for-bit.
